alu_accum: RTL and testbench
============================

ALU_ACCUM -- requirements
Module: alu_accum

Interface
REQ-001 SHALL have parameter WIDTH, default 8, accumulator and operand width (legal 4..32).
REQ-002 SHALL have parameter DEPTH, default 4, undo-history entries (legal 2..16, power of two).
REQ-003 SHALL have port Clock  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset_b  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port A  input  WIDTH  operand.
REQ-006 SHALL have port op  input  3  operation select, sampled with go.
REQ-007 SHALL have port go  input  1  request strobe, one operation per cycle it is high and accepted.
REQ-008 SHALL have port undo  input  1  request to restore the previous accumulator value.
REQ-009 SHALL have port q  output  WIDTH  accumulator, registered.
REQ-010 SHALL have port busy  output  1  high while a multi-cycle multiply runs.
REQ-011 SHALL have port ovf  output  1  overflow or carry of the last completed op, registered.
REQ-012 SHALL have port hist_cnt  output  $clog2(DEPTH)+1  valid undo entries.

Function
REQ-013 SHALL accept go only when busy=0; go while busy=1 SHALL be ignored with no side effects.
REQ-014 SHALL implement ops: 000 q+A; 001 q-A; 010 q&A; 011 q|A; 100 q^A; 101 q<<A[$clog2(WIDTH)-1:0]; 110 q*A (low WIDTH bits); 111 load A.
REQ-015 Ops other than 110 SHALL complete in one cycle: q and ovf update on the edge sampling go; busy stays 0.
REQ-016 Op 110 SHALL use a shift-add FSM with states IDLE and MUL: busy=1 from the accepting edge for exactly WIDTH cycles; q and ovf update on the edge busy returns to 0; q holds its old value meanwhile.
REQ-017 ovf SHALL be: add carry-out; sub borrow (A>q unsigned); mul any nonzero product bit at or above WIDTH; shift any 1 bit shifted out; 0 for logic and load ops.
REQ-018 All arithmetic SHALL be unsigned, modulo 2^WIDTH.
REQ-019 Each accepted go SHALL push the pre-operation q onto the history stack; when hist_cnt=DEPTH the oldest entry SHALL be discarded (circular), hist_cnt saturates at DEPTH.
REQ-020 undo with busy=0, go=0, hist_cnt>0 SHALL pop the newest entry into q, clear ovf, decrement hist_cnt, in one cycle.
REQ-021 undo with hist_cnt=0, or while busy=1, SHALL be ignored.
REQ-022 go and undo high in the same cycle: go SHALL win, undo ignored.
REQ-023 Op 110 SHALL push history at acceptance, not completion.

Reset
REQ-024 Reset_b=0 SHALL immediately force q=0, ovf=0, busy=0, hist_cnt=0, FSM=IDLE, independent of Clock.
REQ-025 Reset during MUL SHALL abort the multiply with no q update after release.
REQ-026 First go SHALL be accepted on the first rising edge after Reset_b returns high.

Configuration
REQ-027 Macro ALU_ACCUM_UNDO_EN defined: history stack, undo and hist_cnt function per REQ-019..REQ-022.
REQ-028 Macro ALU_ACCUM_UNDO_EN undefined: no stack storage; undo ignored; hist_cnt tied 0; all other behaviour identical.

Verification (WIDTH=8, DEPTH=4, macro defined)
REQ-029 Reset, load A=0xF0 (op 111), add A=0x20 -> q=0x10, ovf=1, hist_cnt=2.
REQ-030 q=0x0C, mul A=0x05 -> busy=1 for 8 cycles, q stays 0x0C, then q=0x3C, ovf=0; go pulses during busy ignored.
REQ-031 Five loads 1,2,3,4,5 -> hist_cnt=4; four undos -> q=4,3,2,1; fifth undo ignored, q=1, hist_cnt=0.
REQ-032 go(add A=1) and undo same cycle from q=7, hist_cnt=1 -> q=8, hist_cnt=2.
REQ-033 Reset_b low mid-multiply between edges -> q=0, busy=0, hist_cnt=0 asynchronously; no later q change.
REQ-034 Macro undefined build: sub q=0x03 A=0x05 -> q=0xFE, ovf=1; undo -> q unchanged, hist_cnt=0.

Source files
------------

// File: rtl/alu_accum.sv
// alu_accum: accumulator ALU with shift-add multiplier and undo history.
// Undo history is built only when ALU_ACCUM_UNDO_EN is defined.
module alu_accum #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     Clock,
  input  logic                     Reset_b,
  input  logic [WIDTH-1:0]         A,
  input  logic [2:0]               op,
  input  logic                     go,
  input  logic                     undo,
  output logic [WIDTH-1:0]         q,
  output logic                     busy,
  output logic                     ovf,
  output logic [$clog2(DEPTH):0]   hist_cnt
);

  localparam int SW = $clog2(WIDTH);
  localparam int HW = $clog2(DEPTH);

  typedef enum logic {
    IDLE,
    MUL
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic                 ovf_q, ovf_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [SW-1:0]        cnt_q, cnt_d;

  logic                 accept;
  logic                 pop_ok;
  logic [WIDTH-1:0]     pop_val;

  logic [WIDTH:0]       sum;
  logic [WIDTH:0]       diff;
  logic [3*WIDTH-1:0]   shl;
  logic [2*WIDTH-1:0]   prod_add;
  logic [WIDTH-1:0]     alu_res;
  logic                 alu_ovf;

  assign accept = go && (state_q == IDLE);

  assign sum  = {1'b0, acc_q} + {1'b0, A};
  assign diff = {1'b0, acc_q} - {1'b0, A};
  assign shl  = {{(2*WIDTH){1'b0}}, acc_q} << A[SW-1:0];

  assign prod_add = prod_q + (mplier_q[0] ? mcand_q : '0);

  // Single-cycle ALU result and flag for the sampled op
  always_comb begin
    alu_res = acc_q;
    alu_ovf = 1'b0;
    unique case (op)
      3'b000: begin
        alu_res = sum[WIDTH-1:0];
        alu_ovf = sum[WIDTH];
      end
      3'b001: begin
        alu_res = diff[WIDTH-1:0];
        alu_ovf = diff[WIDTH];
      end
      3'b010: alu_res = acc_q & A;
      3'b011: alu_res = acc_q | A;
      3'b100: alu_res = acc_q ^ A;
      3'b101: begin
        alu_res = shl[WIDTH-1:0];
        alu_ovf = |shl[3*WIDTH-1:WIDTH];
      end
      3'b110: begin
        alu_res = acc_q;
        alu_ovf = 1'b0;
      end
      3'b111: alu_res = A;
      default: begin
        alu_res = acc_q;
        alu_ovf = 1'b0;
      end
    endcase
  end

  // Next state: accept ops, run the multiply, or apply an undo
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (op == 3'b110) begin
            state_d  = MUL;
            mcand_d  = {{WIDTH{1'b0}}, acc_q};
            mplier_d = A;
            prod_d   = '0;
            cnt_d    = '0;
          end else begin
            acc_d = alu_res;
            ovf_d = alu_ovf;
          end
        end else if (pop_ok) begin
          acc_d = pop_val;
          ovf_d = 1'b0;
        end
      end
      MUL: begin
        prod_d   = prod_add;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == SW'(WIDTH - 1)) begin
          state_d = IDLE;
          acc_d   = prod_add[WIDTH-1:0];
          ovf_d   = |prod_add[2*WIDTH-1:WIDTH];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and FSM registers
  always_ff @(posedge Clock or negedge Reset_b) begin
    if (!Reset_b) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      ovf_q    <= ovf_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
    end
  end

`ifdef ALU_ACCUM_UNDO_EN
  logic [WIDTH-1:0] hmem [DEPTH];
  logic [HW-1:0]    wp_q;
  logic [HW:0]      hc_q;

  assign pop_ok  = undo && !go && (state_q == IDLE) && (hc_q != '0);
  assign pop_val = hmem[wp_q - HW'(1)];
  assign hist_cnt = hc_q;

  // Circular stack pointer and saturating fill count
  always_ff @(posedge Clock or negedge Reset_b) begin
    if (!Reset_b) begin
      wp_q <= '0;
      hc_q <= '0;
    end else if (accept) begin
      wp_q <= wp_q + HW'(1);
      if (hc_q != (HW+1)'(DEPTH)) begin
        hc_q <= hc_q + 1'b1;
      end
    end else if (pop_ok) begin
      wp_q <= wp_q - HW'(1);
      hc_q <= hc_q - 1'b1;
    end
  end

  // History storage, newest entry overwrites the oldest when full
  always_ff @(posedge Clock) begin
    if (accept) begin
      hmem[wp_q] <= acc_q;
    end
  end
`else
  logic unused_undo;

  assign unused_undo = undo;
  assign pop_ok      = 1'b0;
  assign pop_val     = '0;
  assign hist_cnt    = '0;
`endif

  assign q    = acc_q;
  assign ovf  = ovf_q;
  assign busy = (state_q == MUL);

endmodule

// File: tb/tb_alu_accum.sv
// tb_alu_accum: scoreboard bench for alu_accum.
// Model tracks values with plain integer arithmetic and a history queue.
module tb_alu_accum;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int HC = $clog2(D) + 1;
  localparam int MASK = (1 << W) - 1;
  localparam int SHM  = (1 << $clog2(W)) - 1;

  logic           Clock = 1'b0;
  logic           Reset_b = 1'b0;
  logic [W-1:0]   A = '0;
  logic [2:0]     op = '0;
  logic           go = 1'b0;
  logic           undo = 1'b0;
  logic [W-1:0]   q;
  logic           busy;
  logic           ovf;
  logic [HC-1:0]  hist_cnt;

  alu_accum #(.WIDTH(W), .DEPTH(D)) dut (
    .Clock(Clock), .Reset_b(Reset_b), .A(A), .op(op),
    .go(go), .undo(undo), .q(q), .busy(busy), .ovf(ovf),
    .hist_cnt(hist_cnt)
  );

  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  typedef struct {
    int tgt;
    int q;
    int ovf;
    int busy;
    int hc;
  } exp_t;

  exp_t sb[$];
  int n_chk = 0;
  int n_fail = 0;

  // reference model state
  int m_q = 0;
  int m_ovf = 0;
  int hist[$];
  int mul_left = 0;
  int pend_q = 0;
  int pend_ovf = 0;

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // monitor: compare every expectation due at this cycle
  always @(negedge Clock) begin
    while (sb.size() > 0 && sb[0].tgt <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      if (e.tgt < cyc) chk("late", e.tgt, cyc);
      chk("q", int'(q), e.q);
      chk("ovf", int'(ovf), e.ovf);
      chk("busy", int'(busy), e.busy);
      chk("hist_cnt", int'(hist_cnt), e.hc);
    end
  end

  function automatic int hsize();
`ifdef ALU_ACCUM_UNDO_EN
    return hist.size();
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    m_q = 0;
    m_ovf = 0;
    hist.delete();
    mul_left = 0;
  endtask

  task automatic model(input bit g, input int o, input int a, input bit u);
    longint v;
    if (mul_left > 0) begin
      mul_left--;
      if (mul_left == 0) begin
        m_q = pend_q;
        m_ovf = pend_ovf;
      end
    end else if (g) begin
`ifdef ALU_ACCUM_UNDO_EN
      hist.push_back(m_q);
      if (hist.size() > D) void'(hist.pop_front());
`endif
      case (o)
        0: begin
          v = m_q + a;
          m_ovf = (v > MASK) ? 1 : 0;
          m_q = int'(v) & MASK;
        end
        1: begin
          m_ovf = (a > m_q) ? 1 : 0;
          m_q = (m_q - a) & MASK;
        end
        2: begin m_q = m_q & a; m_ovf = 0; end
        3: begin m_q = m_q | a; m_ovf = 0; end
        4: begin m_q = m_q ^ a; m_ovf = 0; end
        5: begin
          v = longint'(m_q) << (a & SHM);
          m_ovf = ((v >> W) != 0) ? 1 : 0;
          m_q = int'(v & MASK);
        end
        6: begin
          v = longint'(m_q) * longint'(a);
          pend_ovf = ((v >> W) != 0) ? 1 : 0;
          pend_q = int'(v & MASK);
          mul_left = W;
        end
        default: begin m_q = a; m_ovf = 0; end
      endcase
    end else if (u) begin
`ifdef ALU_ACCUM_UNDO_EN
      if (hist.size() > 0) begin
        m_q = hist.pop_back();
        m_ovf = 0;
      end
`endif
    end
  endtask

  // called at a negedge: drive, predict, wait for next negedge
  task automatic step(input bit g, input int o, input int a, input bit u);
    exp_t e;
    go = g;
    op = 3'(o);
    A = W'(a);
    undo = u;
    model(g, o, a, u);
    e.tgt = cyc + 1;
    e.q = m_q;
    e.ovf = m_ovf;
    e.busy = (mul_left > 0) ? 1 : 0;
    e.hc = hsize();
    sb.push_back(e);
    @(negedge Clock);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  task automatic do_reset();
    #1;
    Reset_b = 1'b0;
    go = 0;
    undo = 0;
    model_reset();
    #1;
    chk("rst_q", int'(q), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_hc", int'(hist_cnt), 0);
    sb.delete();
    @(negedge Clock);
    Reset_b = 1'b1;
  endtask

  initial begin
    @(negedge Clock);
    do_reset();

    // load F0, add 20: carry
    step(1, 7, 8'hF0, 0);
    step(1, 0, 8'h20, 0);
    idle(1);

    // multiply 0C*05 with ignored go pulses
    step(1, 7, 8'h0C, 0);
    step(1, 6, 8'h05, 0);
    for (int i = 0; i < 4; i++) begin
      step(1, 7, 8'hFF, 0);
      step(0, 0, 0, 1);
    end
    idle(3);

    // history fill and drain
    do_reset();
    for (int i = 1; i <= 5; i++) step(1, 7, i, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1);
    idle(1);

    // go beats undo
    do_reset();
    step(1, 7, 7, 0);
    step(1, 0, 1, 1);
    idle(1);

    // subtract with borrow then undo
    do_reset();
    step(1, 7, 3, 0);
    step(1, 1, 5, 0);
    step(0, 0, 0, 1);
    idle(1);

    // shift boundaries and a high-overflow multiply
    step(1, 7, 8'h81, 0);
    step(1, 5, 1, 0);
    step(1, 7, 8'h81, 0);
    step(1, 5, 8'hF8, 0);
    step(1, 7, 8'hFF, 0);
    step(1, 6, 8'hFF, 0);
    idle(W + 1);

    // asynchronous reset mid-multiply
    step(1, 7, 8'h33, 0);
    step(1, 6, 8'h07, 0);
    idle(3);
    #2;
    Reset_b = 1'b0;
    #1;
    chk("amid_q", int'(q), 0);
    chk("amid_busy", int'(busy), 0);
    chk("amid_hc", int'(hist_cnt), 0);
    model_reset();
    sb.delete();
    @(negedge Clock);
    Reset_b = 1'b1;
    idle(W + 2);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)),
           int'($urandom_range(0, MASK)), $urandom_range(0, 1) == 1);
    end
    idle(W + 2);
    #1;
    if (sb.size() != 0) chk("sb_drain", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
